// File: rtl/serial_bus_arb_pkg.sv
// Shared types and helpers for the serial bus arbiter.
//   arb_state_e     : arbiter FSM states
//   DEFAULT_TIMEOUT : default watchdog hold limit in grant cycles
//   onehot_to_idx   : encodes a one-hot vector (up to 8 bits) to its index
package serial_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    BUSY         = 2'd1,
    SPLIT_RESUME = 2'd2
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;
  localparam int unsigned MAX_MASTERS     = 8;
  localparam int unsigned MAX_SEL_W       = 3;

  // OR of the indices of all set bits; exact for a one-hot or all-zero input
  function automatic logic [MAX_SEL_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [MAX_SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | MAX_SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin search over masked requests.
//   req   : per-master request
//   mask  : per-master eligibility (1 = may be picked)
//   last  : index of the previous owner; the search starts at last+1
//   found : some eligible request exists
//   index : first eligible requester at or after last+1, modulo NUM_MASTERS
module rr_priority_picker
  import serial_bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned SEL_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic [SEL_W-1:0]       last,
  output logic                   found,
  output logic [SEL_W-1:0]       index
);

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] winner;
  logic [SEL_W-1:0]       cand;
  logic [MAX_SEL_W-1:0]   win_idx;

  assign elig = req & mask;

  // Walk last+1 .. last+NUM_MASTERS; first hit wins
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = SEL_W'((32'(last) + k) % NUM_MASTERS);
      if ((winner == '0) && elig[cand]) winner[cand] = 1'b1;
    end
  end

  assign found   = |winner;
  assign win_idx = onehot_to_idx(MAX_MASTERS'(winner));
  assign index   = SEL_W'(win_idx);

endmodule

// File: rtl/serial_bus_arbiter.sv
// Serial bus arbiter: round-robin ownership, one outstanding split, hold watchdog.
//   clk, rstn   : clock, synchronous active-low reset
//   mreq        : per-master request, held for the whole transaction
//   ssplit      : split pulse from the addressed slave
//   sready      : split slave ready, allows resuming the split master
//   mgrant      : registered one-hot grant
//   msel        : owner index, holds its value while idle
//   bus_busy    : a grant is active
//   split_grant : resumed split master owns the bus
//   timeout_err : one-cycle pulse on watchdog release
module serial_bus_arbiter
  import serial_bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned SEL_W       = $clog2(NUM_MASTERS),
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] mreq,
  input  logic                   ssplit,
  input  logic                   sready,
  output logic [NUM_MASTERS-1:0] mgrant,
  output logic [SEL_W-1:0]       msel,
  output logic                   bus_busy,
  output logic                   split_grant,
  output logic                   timeout_err
);

  localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [SEL_W-1:0]       owner_q, owner_d;
  logic [SEL_W-1:0]       last_q, last_d;
  logic                   split_pending_q, split_pending_d;
  logic [SEL_W-1:0]       split_owner_q, split_owner_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [NUM_MASTERS-1:0] mgrant_q, mgrant_d;
  logic                   busy_q, busy_d;
  logic                   sgrant_q, sgrant_d;
  logic                   terr_q, terr_d;

  logic [NUM_MASTERS-1:0] elig_mask;
  logic                   pick_found;
  logic [SEL_W-1:0]       pick_idx;
  logic                   wd_hit;

  // The split master may only come back through the resume path
  assign elig_mask = split_pending_q ? ~(NUM_MASTERS'(1) << split_owner_q) : '1;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .SEL_W       (SEL_W)
  ) u_picker (
    .req   (mreq),
    .mask  (elig_mask),
    .last  (last_q),
    .found (pick_found),
    .index (pick_idx)
  );

  assign wd_hit = (TIMEOUT != 0) && (hold_cnt_q == CNT_W'(TIMEOUT - 1));

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      owner_q         <= '0;
      last_q          <= LAST_RST;
      split_pending_q <= 1'b0;
      split_owner_q   <= '0;
      hold_cnt_q      <= '0;
      mgrant_q        <= '0;
      busy_q          <= 1'b0;
      sgrant_q        <= 1'b0;
      terr_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_q          <= last_d;
      split_pending_q <= split_pending_d;
      split_owner_q   <= split_owner_d;
      hold_cnt_q      <= hold_cnt_d;
      mgrant_q        <= mgrant_d;
      busy_q          <= busy_d;
      sgrant_q        <= sgrant_d;
      terr_q          <= terr_d;
    end
  end

  // Next-state, bookkeeping and registered-output decode
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    split_pending_d = split_pending_q;
    split_owner_d   = split_owner_q;
    hold_cnt_d      = hold_cnt_q;
    terr_d          = 1'b0;

    // Split master gave up while waiting for its slave
    if (split_pending_q && !mreq[split_owner_q] && (state_q != SPLIT_RESUME)) begin
      split_pending_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (split_pending_q && sready && mreq[split_owner_q]) begin
          state_d    = SPLIT_RESUME;
          owner_d    = split_owner_q;
          hold_cnt_d = '0;
        end else if (pick_found) begin
          state_d    = BUSY;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      BUSY: begin
        if (ssplit) begin
          // Only the first split is remembered; later ones are plain releases
          state_d = IDLE;
          last_d  = owner_q;
          if (!split_pending_q) begin
            split_pending_d = 1'b1;
            split_owner_d   = owner_q;
          end
        end else if (!mreq[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (wd_hit) begin
          state_d = IDLE;
          last_d  = owner_q;
          terr_d  = 1'b1;
          if (split_pending_q && (split_owner_q == owner_q)) split_pending_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      SPLIT_RESUME: begin
        if (ssplit) begin
          state_d         = IDLE;
          last_d          = owner_q;
          split_pending_d = 1'b1;
          split_owner_d   = owner_q;
        end else if (!mreq[owner_q]) begin
          state_d         = IDLE;
          last_d          = owner_q;
          split_pending_d = 1'b0;
        end else if (wd_hit) begin
          state_d         = IDLE;
          last_d          = owner_q;
          terr_d          = 1'b1;
          split_pending_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    sgrant_d = (state_d == SPLIT_RESUME);
    mgrant_d = busy_d ? (NUM_MASTERS'(1) << owner_d) : '0;
  end

  assign mgrant      = mgrant_q;
  assign msel        = owner_q;
  assign bus_busy    = busy_q;
  assign split_grant = sgrant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model.
module tb_serial_bus_arbiter;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  mreq;
  logic          ssplit;
  logic          sready;
  logic [N-1:0]  mgrant;
  logic [SW-1:0] msel;
  logic          bus_busy;
  logic          split_grant;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_bus_arbiter #(
    .NUM_MASTERS (N),
    .SEL_W       (SW),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mreq        (mreq),
    .ssplit      (ssplit),
    .sready      (sready),
    .mgrant      (mgrant),
    .msel        (msel),
    .bus_busy    (bus_busy),
    .split_grant (split_grant),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [N-1:0] g, input logic bb,
                     input logic sg, input logic te);
    chk({nm, ".mgrant"}, 32'(mgrant), 32'(g));
    chk({nm, ".bus_busy"}, 32'(bus_busy), 32'(bb));
    chk({nm, ".split_grant"}, 32'(split_grant), 32'(sg));
    chk({nm, ".timeout_err"}, 32'(timeout_err), 32'(te));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; mreq = '0; ssplit = 1'b0; sready = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  // Transaction-level model: who owns the bus, for how many cycles so far,
  // and which master (if any) is parked on a split.
  int m_cur     = -1;
  int m_last    = N - 1;
  int m_pown    = 0;
  int m_held    = 0;
  int m_sel     = 0;
  bit m_pend    = 1'b0;
  bit m_resumed = 1'b0;
  bit m_terr    = 1'b0;

  always @(posedge clk) begin : model
    bit old_pend;
    bit found;
    int m;
    if (!rstn) begin
      m_cur = -1; m_last = N - 1; m_pown = 0; m_held = 0; m_sel = 0;
      m_pend = 1'b0; m_resumed = 1'b0; m_terr = 1'b0;
    end else begin
      old_pend = m_pend;
      m_terr   = 1'b0;
      if (m_pend && !mreq[m_pown] && (m_cur != m_pown)) m_pend = 1'b0;
      if (m_cur < 0) begin
        if (old_pend && sready && mreq[m_pown]) begin
          m_cur = m_pown; m_resumed = 1'b1; m_held = 1;
        end else begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            m = (m_last + k) % N;
            if (!found && mreq[m] && !(old_pend && (m == m_pown))) begin
              found = 1'b1; m_cur = m; m_resumed = 1'b0; m_held = 1;
            end
          end
        end
      end else if (ssplit) begin
        if (m_resumed || !old_pend) begin
          m_pend = 1'b1; m_pown = m_cur;
        end
        m_last = m_cur; m_cur = -1;
      end else if (!mreq[m_cur]) begin
        if (m_resumed) m_pend = 1'b0;
        m_last = m_cur; m_cur = -1;
      end else if ((TO > 0) && (m_held == TO)) begin
        m_terr = 1'b1;
        if (old_pend && (m_pown == m_cur)) m_pend = 1'b0;
        m_last = m_cur; m_cur = -1;
      end else begin
        m_held++;
      end
      if (m_cur >= 0) m_sel = m_cur;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin : compare
    logic [N-1:0] eg;
    eg = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
    chk("cyc.mgrant", 32'(mgrant), 32'(eg));
    chk("cyc.msel", 32'(msel), 32'(m_sel));
    chk("cyc.bus_busy", 32'(bus_busy), 32'(m_cur >= 0));
    chk("cyc.split_grant", 32'(split_grant), 32'(m_cur >= 0 && m_resumed));
    chk("cyc.timeout_err", 32'(timeout_err), 32'(m_terr));
  end

  initial begin : time_limit
    #1000000;
    $display("FAIL time_limit: bench did not finish, got running expected done");
    $fatal(1);
  end

  initial begin : stim
    int order[$];
    int cntg[N];
    int idle_run;
    logic prev_busy;

    rstn = 1'b0; mreq = '0; ssplit = 1'b0; sready = 1'b0;
    step(); step();
    lit("reset", '0, 1'b0, 1'b0, 1'b0);
    chk("reset.msel", 32'(msel), 32'd0);

    // Single requester
    rstn = 1'b1; step();
    mreq = 3'b001; step();
    lit("single_grant", 3'b001, 1'b1, 1'b0, 1'b0);
    chk("single_grant.msel", 32'(msel), 32'd0);
    repeat (6) step();
    lit("single_hold", 3'b001, 1'b1, 1'b0, 1'b0);
    mreq = '0; step();
    lit("single_release", '0, 1'b0, 1'b0, 1'b0);

    // Round robin: masters 0 and 1, each releasing after 4 grant cycles
    do_reset();
    mreq = 3'b011;
    for (int i = 0; i < N; i++) cntg[i] = 0;
    idle_run = 0; prev_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus_busy && !prev_busy) begin
        order.push_back(int'(msel));
        if (order.size() > 1) chk("rr_gap", 32'(idle_run), 32'd1);
      end
      idle_run  = bus_busy ? 0 : idle_run + 1;
      prev_busy = bus_busy;
      for (int i = 0; i < N; i++) cntg[i] = mgrant[i] ? cntg[i] + 1 : 0;
      mreq = 3'b011;
      for (int i = 0; i < 2; i++) if (cntg[i] == 4) mreq[i] = 1'b0;
    end
    chk("rr_count", 32'(order.size() >= 4), 32'd1);
    for (int j = 0; j < 4; j++) chk("rr_order", 32'(order[j]), 32'(j % 2));

    // Split with master 1 taking over while master 0 waits on its slave
    do_reset();
    mreq = 3'b011; step();
    lit("split_m0", 3'b001, 1'b1, 1'b0, 1'b0);
    ssplit = 1'b1; step(); ssplit = 1'b0;
    lit("split_drop", '0, 1'b0, 1'b0, 1'b0);
    step();
    lit("split_m1", 3'b010, 1'b1, 1'b0, 1'b0);
    repeat (3) begin step(); lit("split_m1_hold", 3'b010, 1'b1, 1'b0, 1'b0); end
    mreq = 3'b001; step();
    lit("split_m1_rel", '0, 1'b0, 1'b0, 1'b0);
    step();
    lit("split_wait", '0, 1'b0, 1'b0, 1'b0);
    sready = 1'b1; step(); sready = 1'b0;
    lit("split_resume", 3'b001, 1'b1, 1'b1, 1'b0);
    step();
    lit("split_resume_hold", 3'b001, 1'b1, 1'b1, 1'b0);
    mreq = '0; step();
    lit("split_done", '0, 1'b0, 1'b0, 1'b0);
    mreq = 3'b001; step();
    lit("split_cleared", 3'b001, 1'b1, 1'b0, 1'b0);
    mreq = '0; step();

    // Split and release in the same cycle: split wins
    do_reset();
    mreq = 3'b001; step();
    lit("sim_m0", 3'b001, 1'b1, 1'b0, 1'b0);
    ssplit = 1'b1; mreq = '0; step();
    ssplit = 1'b0; mreq = 3'b011;
    lit("sim_drop", '0, 1'b0, 1'b0, 1'b0);
    step();
    lit("sim_m1", 3'b010, 1'b1, 1'b0, 1'b0);
    mreq = 3'b001; step();
    lit("sim_m1_rel", '0, 1'b0, 1'b0, 1'b0);
    step();
    lit("sim_pending", '0, 1'b0, 1'b0, 1'b0);
    sready = 1'b1; step(); sready = 1'b0;
    lit("sim_resume", 3'b001, 1'b1, 1'b1, 1'b0);
    mreq = '0; step();

    // Watchdog: master 1 holds past TO grant cycles
    do_reset();
    mreq = 3'b010; step();
    lit("wd_first", 3'b010, 1'b1, 1'b0, 1'b0);
    mreq = 3'b011;
    for (int i = 2; i <= TO; i++) begin step(); lit("wd_hold", 3'b010, 1'b1, 1'b0, 1'b0); end
    step();
    lit("wd_release", '0, 1'b0, 1'b0, 1'b1);
    step();
    lit("wd_next_m0", 3'b001, 1'b1, 1'b0, 1'b0);
    mreq = '0; step();

    // Reset while busy with a split pending
    do_reset();
    mreq = 3'b011; step();
    ssplit = 1'b1; step(); ssplit = 1'b0;
    step();
    lit("rst_busy_m1", 3'b010, 1'b1, 1'b0, 1'b0);
    rstn = 1'b0; step();
    lit("rst_mid", '0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.msel", 32'(msel), 32'd0);
    rstn = 1'b1; step();
    lit("rst_first_m0", 3'b001, 1'b1, 1'b0, 1'b0);
    mreq = '0; step();

    // Randomized traffic, checked by the compare process
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) mreq[i] = ~mreq[i];
      ssplit = ($urandom_range(0, 9) == 0);
      sready = ($urandom_range(0, 3) == 0);
      rstn   = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
